// File: rtl/led_cube_scan_ctrl.sv
// Refresh scheduler for the 8x8x8 LED cube: loads the column latches byte by
// byte, drives one layer at a time with blanking, and paces frame hand-off.
module led_cube_scan_ctrl #(
    parameter int ON_CYCLES    = 1000,
    parameter int BLANK_CYCLES = 4,
    parameter int FRAME_REPEAT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       frame_avail,
    input  logic [7:0] buf_data,
    output logic [5:0] frame_addr,
    output logic [7:0] col_data,
    output logic [7:0] latch_sel,
    output logic       latch_stb,
    output logic [7:0] layer_en,
    output logic       frame_ack,
    output logic       busy
);

    localparam int TMAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = (FRAME_REPEAT > 1) ? $clog2(FRAME_REPEAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        BLANK,
        SETUP,
        STROBE,
        DISPLAY
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     layer_q, layer_d;
    logic [2:0]     col_q, col_d;
    logic [RW-1:0]  rep_q, rep_d;
    logic [TW-1:0]  timer_q, timer_d;

    logic [5:0]     frame_addr_q, frame_addr_d;
    logic [7:0]     col_data_q, col_data_d;
    logic [7:0]     latch_sel_q, latch_sel_d;
    logic           latch_stb_q, latch_stb_d;
    logic [7:0]     layer_en_q, layer_en_d;
    logic           frame_ack_q, frame_ack_d;
    logic           busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        layer_d     = layer_q;
        col_d       = col_q;
        rep_d       = rep_q;
        timer_d     = timer_q;
        col_data_d  = col_data_q;
        frame_ack_d = 1'b0;

        if (!run) begin
            state_d = IDLE;
            layer_d = 3'd0;
            col_d   = 3'd0;
            rep_d   = '0;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    layer_d = 3'd0;
                    col_d   = 3'd0;
                    rep_d   = '0;
                    timer_d = '0;
                end
                BLANK: begin
                    if (timer_q == TW'(BLANK_CYCLES - 1)) begin
                        state_d = SETUP;
                        col_d   = 3'd0;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                SETUP: begin
                    state_d    = STROBE;
                    col_data_d = buf_data;
                end
                STROBE: begin
                    if (col_q == 3'd7) begin
                        state_d = DISPLAY;
                        timer_d = '0;
                    end else begin
                        col_d   = col_q + 3'd1;
                        state_d = SETUP;
                    end
                end
                DISPLAY: begin
                    if (timer_q == TW'(ON_CYCLES - 1)) begin
                        timer_d = '0;
                        state_d = BLANK;
                        if (layer_q != 3'd7) begin
                            layer_d = layer_q + 3'd1;
                        end else begin
                            // Scan end: frame_avail is only looked at here.
                            layer_d = 3'd0;
                            if (rep_q != RW'(FRAME_REPEAT - 1)) begin
                                rep_d = rep_q + 1'b1;
                            end else if (frame_avail) begin
                                frame_ack_d = 1'b1;
                                rep_d       = '0;
                            end
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Outputs are registered from the next state so they line up with it.
        busy_d       = (state_d != IDLE);
        frame_addr_d = (state_d == IDLE) ? 6'd0 : {layer_d, col_d};
        latch_stb_d  = (state_d == STROBE);
        latch_sel_d  = (state_d == STROBE) ? (8'd1 << col_d) : 8'd0;
        layer_en_d   = (state_d == DISPLAY) ? (8'd1 << layer_d) : 8'd0;
        if (state_d == IDLE) begin
            col_data_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            layer_q      <= 3'd0;
            col_q        <= 3'd0;
            rep_q        <= '0;
            timer_q      <= '0;
            frame_addr_q <= 6'd0;
            col_data_q   <= 8'd0;
            latch_sel_q  <= 8'd0;
            latch_stb_q  <= 1'b0;
            layer_en_q   <= 8'd0;
            frame_ack_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            layer_q      <= layer_d;
            col_q        <= col_d;
            rep_q        <= rep_d;
            timer_q      <= timer_d;
            frame_addr_q <= frame_addr_d;
            col_data_q   <= col_data_d;
            latch_sel_q  <= latch_sel_d;
            latch_stb_q  <= latch_stb_d;
            layer_en_q   <= layer_en_d;
            frame_ack_q  <= frame_ack_d;
            busy_q       <= busy_d;
        end
    end

    assign frame_addr = frame_addr_q;
    assign col_data   = col_data_q;
    assign latch_sel  = latch_sel_q;
    assign latch_stb  = latch_stb_q;
    assign layer_en   = layer_en_q;
    assign frame_ack  = frame_ack_q;
    assign busy       = busy_q;

endmodule

// File: doc/led_cube_scan_ctrl.md
Name: led_cube_scan_ctrl

Overview:
- Refresh scheduler for the 8x8x8 LED cube. Sequences reads of the frame stream buffer via frame_addr and loads the 8 column latches one byte at a time.
- Multiplexes the 8 layer drivers with blanking between layers.
- Holds each frame for a configurable number of full-cube refreshes, then acknowledges the stream writer so the next buffered frame is presented.
- Sits between the stream buffer and the latch/layer driver pins.

Parameters:
- ON_CYCLES, 1000, clk cycles each layer is driven (>=1).
- BLANK_CYCLES, 4, clk cycles with all layers off before each layer load (>=1).
- FRAME_REPEAT, 8, full-cube scans per frame before frame_ack may be issued (>=1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset: synchronous, active-low.
- run  input  1  scan enable (streaming mode active). Low forces IDLE.
- frame_avail  input  1  stream buffer holds a newer complete frame.
- buf_data  input  8  byte from stream buffer at frame_addr; combinational, same cycle.
- frame_addr  output  6  buffer read address = {layer[2:0], col[2:0]}.
- col_data  output  8  registered byte presented to the column latches.
- latch_sel  output  8  one-hot column latch select; 0 when not loading.
- latch_stb  output  1  latch strobe; 1-cycle pulse.
- layer_en  output  8  one-hot layer drive, active-high.
- frame_ack  output  1  1-cycle pulse: current frame consumed, buffer may advance.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset, and any cycle with rst_n=0: state=IDLE, layer=0, col=0, rep_cnt=0, timer=0. All outputs 0 (frame_addr=0, col_data=0, latch_sel=0, latch_stb=0, layer_en=0, frame_ack=0, busy=0).
- States: IDLE, BLANK, SETUP, STROBE, DISPLAY. All outputs are registered.
- IDLE: if run=1, go to BLANK next cycle with timer=0, layer=0, col=0, rep_cnt=0.
- BLANK:
  - layer_en=0, latch_sel=0.
  - Stays exactly BLANK_CYCLES cycles, then goes to SETUP with col=0.
- SETUP (1 cycle):
  - frame_addr={layer,col}.
  - col_data is captured from buf_data at the end of this cycle.
  - latch_sel=onehot(col) is registered alongside col_data.
- STROBE (1 cycle):
  - latch_stb=1; col_data and latch_sel are held stable.
  - If col<7: col+1, go to SETUP.
  - If col=7: go to DISPLAY.
  - Each byte takes 2 cycles; a layer load takes 16 cycles.
- DISPLAY:
  - latch_sel=0; layer_en=onehot(layer) for exactly ON_CYCLES cycles.
  - Exit: if layer<7, layer+1 and go to BLANK.
  - If layer=7, layer=0 and the end-of-scan rule applies before going to BLANK.
- End-of-scan rule:
  - if rep_cnt < FRAME_REPEAT-1: rep_cnt+1.
  - else if frame_avail=1: frame_ack=1 for exactly one cycle (the first BLANK cycle of the next scan), rep_cnt=0.
  - else: rep_cnt stays saturated at FRAME_REPEAT-1 and the frame is repeated. The check runs again at each later scan end.
  - frame_avail is sampled only at scan end and never interrupts a scan.
- Layer period = BLANK_CYCLES + 16 + ON_CYCLES. Scan period = 8 x layer period.
- Only one layer_en bit is ever high. layer_en is never high while latch_stb=1.
- run deasserted in any state: next cycle is IDLE with all outputs 0 and no frame_ack. A partial scan is abandoned; the next run restarts from layer 0 with rep_cnt=0.
- run and frame_avail changing together at scan end: run=0 wins, so no ack.
- Counters are sized to hold max(ON_CYCLES, BLANK_CYCLES). col, layer and rep_cnt wrap only as specified.

Test Plan:
- Params ON=4, BLANK=2, REPEAT=2. Reset then run=1 at cycle 0 -> busy=1 from cycle 1. First latch_stb at cycle 4 with latch_sel=8'h01 and col_data=buf[0]. 8 strobes at 2-cycle spacing. layer_en=8'h01 for 4 cycles. Layer period 22 cycles.
- Buffer preloaded with addr-value pattern (buf[a]=a) -> strobe k of layer L carries col_data=8L+k and latch_sel=1<<k. layer_en steps 01,02,...,80, then wraps to 01.
- frame_avail=1 constant -> frame_ack pulses once every 2 scans (352 cycles), each time for 1 cycle, coincident with the first BLANK cycle after layer 7.
- frame_avail=0 for 5 scans, then 1 -> no ack during those scans. Ack at the first scan end after frame_avail rises. rep_cnt never exceeds 1.
- run dropped mid-DISPLAY of layer 3 -> next cycle all outputs 0, busy=0, no ack. Run reasserted -> restart at layer 0, first strobe 4 cycles later.
- rst_n=0 for 1 cycle mid-STROBE -> next cycle all outputs 0, state IDLE. Throughout all tests assert layer_en is one-hot or 0, and latch_stb&|layer_en is never set.
